clk_div_monitor: RTL



---
 rtl/clk_div_monitor.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// Frequency/lock monitor for a divided clock, running in the source clock domain.
// The divided clock is synchronized and its rising edges are detected. Each period
// is measured in source cycles and compared against EXP_PERIOD +/- TOL. The block
// reports lock, fault, a per-missing-edge timeout strobe and a saturating error count.
module clk_div_monitor #(
  parameter int unsigned EXP_PERIOD = 3,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             in,
  input  logic             reset,
  input  logic             div_in,
  input  logic             enable,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             lock,
  output logic             fault,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned LoBound = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
  localparam int unsigned HiBound = EXP_PERIOD + TOL;
  localparam int unsigned GoodW   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

  localparam logic [CNT_W-1:0] LoCnt    = CNT_W'(LoBound);
  localparam logic [CNT_W-1:0] HiCnt    = CNT_W'(HiBound);
  localparam logic [CNT_W-1:0] ToLimit  = CNT_W'(HiBound + 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
  localparam logic [ERR_W-1:0] ErrMax   = '1;
  localparam logic [GoodW-1:0] LockLast = GoodW'(LOCK_CNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StAcq,
    StLocked,
    StFault
  } state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [GoodW-1:0] good_q;
  // Set once a timeout has fired for the current missing edge; cleared by the next rise.
  logic             to_fired_q;

  logic rise;
  logic active;
  logic period_good;
  logic eval;
  logic good_evt;
  logic bad_evt;
  logic to_evt;
  logic err_evt;

  // Two-flop synchronizer plus history flop for rising-edge detection.
  always_ff @(posedge in or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= div_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Edge detection and per-cycle event decode.
  always_comb begin
    rise        = s2_q & ~s3_q;
    active      = (state_q == StAcq) || (state_q == StLocked) || (state_q == StFault);
    period_good = (cnt_q >= LoCnt) && (cnt_q <= HiCnt);
    // The rise that ends a timed-out period is reported but not judged again:
    // the timeout already accounted for that missing edge.
    eval        = active && rise && !to_fired_q;
    good_evt    = eval && period_good;
    bad_evt     = eval && !period_good;
    to_evt      = active && !rise && !to_fired_q && (cnt_q == ToLimit);
    err_evt     = bad_evt || to_evt;
  end

  // Monitor FSM, period counter and registered status outputs.
  always_ff @(posedge in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      good_q     <= '0;
      to_fired_q <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      lock       <= 1'b0;
      fault      <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      period_vld <= 1'b0;
      timeout    <= 1'b0;

      if (clr_err) begin
        err_cnt <= '0;
      end else if (enable && err_evt && (err_cnt != ErrMax)) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (!enable) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        good_q     <= '0;
        to_fired_q <= 1'b0;
        lock       <= 1'b0;
        fault      <= 1'b0;
      end else begin
        if (state_q == StIdle) begin
          cnt_q <= '0;
        end else if (rise) begin
          cnt_q <= CNT_W'(1);
        end else if (cnt_q != CntMax) begin
          cnt_q <= cnt_q + 1'b1;
        end

        if (rise) begin
          to_fired_q <= 1'b0;
        end else if (to_evt) begin
          to_fired_q <= 1'b1;
        end

        if (active && rise) begin
          period     <= cnt_q;
          period_vld <= 1'b1;
        end
        timeout <= to_evt;

        case (state_q)
          StIdle: begin
            state_q <= StArm;
          end
          StArm: begin
            if (rise) begin
              state_q <= StAcq;
              good_q  <= '0;
            end
          end
          StAcq, StFault: begin
            if (err_evt) begin
              good_q <= '0;
            end else if (good_evt) begin
              if (good_q == LockLast) begin
                state_q <= StLocked;
                lock    <= 1'b1;
                fault   <= 1'b0;
                good_q  <= '0;
              end else begin
                good_q <= good_q + 1'b1;
              end
            end
          end
          StLocked: begin
            if (err_evt) begin
              state_q <= StFault;
              lock    <= 1'b0;
              fault   <= 1'b1;
              good_q  <= '0;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
